// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder backed by a
// word-addressed storage array, with a fixed number of wait states per access.
// Optional build macro DMEM_RESPONDER_ALIGN_CHECK_EN: when defined, accesses
// with req_addr[1:0] != 0 are rejected with resp_err=1 and no memory access.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Registered state and latched request fields
   state_t         r_state;
   logic [3:0]     r_cnt;
   logic           r_req_ready;
   logic           r_resp_valid;
   logic [31:0]    r_resp_rdata;
   logic           r_resp_err;
   logic           r_write;
   logic [AW-1:0]  r_idx;
   logic [31:0]    r_wdata;
   logic           r_mis;
   logic [31:0]    r_mem [DEPTH_WORDS];

   // Combinational access view: in IDLE the live request is used (zero-wait
   // accesses happen on the accepting edge), otherwise the latched fields.
   logic           w_accept;
   logic           w_enter_resp;
   logic           w_acc_write;
   logic [AW-1:0]  w_acc_idx;
   logic [31:0]    w_acc_wdata;
   logic           w_acc_mis;
   logic           w_req_mis;
   logic           w_mem_we;
   logic [31:0]    w_rsp_rdata;
   logic           w_unused_addr;

   // Address bits outside the word index are intentionally ignored
   assign w_unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
   assign w_req_mis = (req_addr[1:0] != 2'd0);
`else
   assign w_req_mis = 1'b0;
`endif

   // Select access source and decide whether this edge performs the access
   always_comb begin
      w_accept     = req_valid && r_req_ready && (r_state == IDLE);
      w_enter_resp = 1'b0;
      w_acc_write  = 1'b0;
      w_acc_idx    = '0;
      w_acc_wdata  = 32'd0;
      w_acc_mis    = 1'b0;
      if (r_state == IDLE) begin
         w_acc_write  = req_write;
         w_acc_idx    = req_addr[AW+1:2];
         w_acc_wdata  = req_wdata;
         w_acc_mis    = w_req_mis;
         w_enter_resp = w_accept && (WAIT_CYCLES == 0);
      end else begin
         w_acc_write  = r_write;
         w_acc_idx    = r_idx;
         w_acc_wdata  = r_wdata;
         w_acc_mis    = r_mis;
         w_enter_resp = (r_state == WAIT) && (r_cnt == 4'd1);
      end
      w_mem_we = w_enter_resp && w_acc_write && !w_acc_mis;
      if (w_acc_write || w_acc_mis) begin
         w_rsp_rdata = 32'd0;
      end else begin
         w_rsp_rdata = r_mem[w_acc_idx];
      end
   end

   // Storage write port; never cleared, and blocked while reset is asserted
   always_ff @(posedge clk) begin
      if (!rst && w_mem_we) begin
         r_mem[w_acc_idx] <= w_acc_wdata;
      end
   end

   // Request/response FSM with registered handshake and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= 4'd0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_resp_err   <= 1'b0;
         r_write      <= 1'b0;
         r_idx        <= '0;
         r_wdata      <= 32'd0;
         r_mis        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_write     <= req_write;
                  r_idx       <= req_addr[AW+1:2];
                  r_wdata     <= req_wdata;
                  r_mis       <= w_req_mis;
                  r_cnt       <= 4'(WAIT_CYCLES);
                  r_req_ready <= 1'b0;
                  if (w_enter_resp) begin
                     r_state      <= RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= w_rsp_rdata;
                     r_resp_err   <= w_acc_mis;
                  end else begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (w_enter_resp) begin
                  r_state      <= RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= w_rsp_rdata;
                  r_resp_err   <= w_acc_mis;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  r_state      <= IDLE;
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_cnt        <= 4'd0;
               r_req_ready  <= 1'b1;
               r_resp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH_WORDS=256,
// WAIT_CYCLES=2). Expected values are hand-computed constants.
module tb_data_mem_responder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int n_cmp;
   int n_fail;

   data_mem_responder #(
      .DEPTH_WORDS(256),
      .WAIT_CYCLES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction with resp_ready held high; response must first
   // appear in the 3rd cycle after the accepting edge.
   task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err);
      int lat;
      lat = 99;
      @(negedge clk);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_addr   = addr;
      req_wdata  = wd;
      resp_ready = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         if (resp_valid === 1'b1) begin
            lat = c;
            break;
         end
      end
      chk({tag, "_latency"}, lat, 32'd3);
      chk({tag, "_rdata"}, resp_rdata, exp_rd);
      chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
      @(negedge clk);
      chk({tag, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      n_cmp      = 0;
      n_fail     = 0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      resp_ready = 1'b0;

      // Reset then idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      rst = 1'b0;

      // Store then load same word
      do_req("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
      do_req("ld10", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

      // Backpressure: load held in RESP for 5 cycles, new request ignored
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = 32'h10;
      resp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_arrive", {31'd0, resp_valid}, 32'd1);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'h55555555;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
         chk("bp_hold_rdata", resp_rdata, 32'hDEADBEEF);
         chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);
      chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
      do_req("bp_reload", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

      // Address wrap modulo 1 KiB
      do_req("wrap_st", 1'b1, 32'h400, 32'h12345678, 32'd0, 1'b0);
      do_req("wrap_ld", 1'b0, 32'h000, 32'd0, 32'h12345678, 1'b0);

      // Reset during WAIT of a store discards it
      do_req("pre_st20", 1'b1, 32'h20, 32'h11111111, 32'd0, 1'b0);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_in_wait", {31'd0, req_ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_rst_ready", {31'd0, req_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_valid", {31'd0, resp_valid}, 32'd0);
      end
      do_req("abort_ld20", 1'b0, 32'h20, 32'd0, 32'h11111111, 1'b0);

      // Reset wins over a simultaneous request
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'hABCDABCD;
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 1'b0;
      chk("rstpri_ready", {31'd0, req_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstpri_no_valid", {31'd0, resp_valid}, 32'd0);
      end
      do_req("rstpri_ld20", 1'b0, 32'h20, 32'd0, 32'h11111111, 1'b0);

      // Misaligned load
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
      do_req("ld13", 1'b0, 32'h13, 32'd0, 32'd0, 1'b1);
`else
      do_req("ld13", 1'b0, 32'h13, 32'd0, 32'hDEADBEEF, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words in backing storage (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted per access (range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 means store, 0 means load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 SHALL have port resp_valid, output, 1 bit: response available.
REQ-011 SHALL have port resp_ready, input, 1 bit: initiator accepts the response.
REQ-012 SHALL have port resp_rdata, output, 32 bits: load data.
REQ-013 SHALL have port resp_err, output, 1 bit: error response flag.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; requests are never pipelined or queued.
REQ-016 Acceptance SHALL occur on a clk edge where req_valid and req_ready are both 1.
REQ-017 On acceptance the block SHALL latch req_write, req_addr and req_wdata and load the wait counter with WAIT_CYCLES.
REQ-018 On acceptance the FSM SHALL enter WAIT, or enter RESP directly when WAIT_CYCLES=0.
REQ-019 In WAIT the counter SHALL decrement by 1 per cycle; the FSM SHALL enter RESP on the edge where the counter equals 1.
REQ-020 The memory access SHALL be performed on the edge entering RESP; resp_valid is therefore 1 exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-021 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-022 A load SHALL return the addressed word in resp_rdata.
REQ-023 A store SHALL write req_wdata to the addressed word and return resp_rdata=0.
REQ-024 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until a cycle with resp_ready=1.
REQ-025 On the edge of that resp_ready=1 cycle the FSM SHALL return to IDLE and clear resp_valid; resp_ready=1 already present on the first RESP cycle completes in one cycle.
REQ-026 req_valid in WAIT or RESP SHALL be ignored and SHALL NOT alter latched request fields.
REQ-027 resp_ready outside RESP SHALL be ignored.
REQ-028 A load following a store to the same word SHALL return the stored value.

Reset
REQ-029 When rst=1 at an edge, the block SHALL force the FSM to IDLE, the counter to 0, resp_valid=0, resp_rdata=0 and resp_err=0; req_ready SHALL then be 1 from the next cycle.
REQ-030 Reset SHALL take priority over every other event, including a simultaneous request acceptance.
REQ-031 A store pending in WAIT when reset hits SHALL be discarded, leaving memory unmodified.
REQ-032 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-033 With macro DMEM_RESPONDER_ALIGN_CHECK_EN defined, an accepted request with req_addr[1:0]!=0 SHALL perform no memory access and SHALL respond after normal latency with resp_err=1 and resp_rdata=0.
REQ-034 Without DMEM_RESPONDER_ALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored, resp_err SHALL be tied to 0, and all accesses proceed as aligned.

Verification
REQ-035 Reset then idle: rst high 2 cycles -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-036 Store 0xDEADBEEF to 0x10, then load 0x10, resp_ready held 1, WAIT_CYCLES=2 -> each resp_valid arrives 3 cycles after acceptance; load returns 0xDEADBEEF; store returns 0.
REQ-037 Backpressure: load with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable; new req_valid ignored with req_ready=0; returns to IDLE the cycle after resp_ready=1.
REQ-038 Wrap test, DEPTH_WORDS=256: store 0x12345678 to 0x400, load 0x000 -> returns 0x12345678.
REQ-039 rst asserted during WAIT of a store of 0xCAFEF00D to 0x20 -> later load of 0x20 returns prior contents; resp_valid never asserted for the aborted store.
REQ-040 Load 0x13 with DMEM_RESPONDER_ALIGN_CHECK_EN defined -> resp_err=1, resp_rdata=0; without the macro -> resp_err=0 and returns word 0x10.
